// File: rtl/lfsr_gen_if.sv
// Bus bundle for lfsr_gen: control inputs (en/load/seed_i) and registered outputs.
interface lfsr_gen_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_i;
  logic [WIDTH-1:0] lfsr_o;
  logic             bit_o;
  logic [WIDTH-1:0] count_o;
  logic             wrap_o;
  logic             lockup_o;

  modport master (
    output en, load, seed_i,
    input  lfsr_o, bit_o, count_o, wrap_o, lockup_o
  );

  modport slave (
    input  en, load, seed_i,
    output lfsr_o, bit_o, count_o, wrap_o, lockup_o
  );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with step enable, seed load and period tracking.
// Optional macro LFSR_LOCKUP_RECOVER_EN: replace all-zero states/seeds with SEED.
module lfsr_gen #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
  parameter logic [WIDTH-1:0] SEED  = 4'hE
) (
  input  logic     clk,
  input  logic     reset_n,
  lfsr_gen_if.slave bus
);

  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] st_q, st_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             fb;
  logic [WIDTH-1:0] ns;

  assign fb = ^(s_q & TAPS);
  assign ns = {s_q[WIDTH-2:0], fb};

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic lock_q, lock_d;

  always_comb begin
    s_d    = s_q;
    st_d   = st_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    lock_d = 1'b0;
    if (bus.load) begin
      cnt_d = '0;
      if (bus.seed_i == '0) begin
        s_d    = SEED;
        st_d   = SEED;
        lock_d = 1'b1;
      end else begin
        s_d  = bus.seed_i;
        st_d = bus.seed_i;
      end
    end else if (bus.en) begin
      // A zero state can never leave on its own; restart the period from SEED.
      if (s_q == '0) begin
        s_d    = SEED;
        st_d   = SEED;
        cnt_d  = '0;
        lock_d = 1'b1;
      end else begin
        s_d = ns;
        if (ns == st_q) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lock_q <= 1'b0;
    else          lock_q <= lock_d;
  end

  assign bus.lockup_o = lock_q;
`else
  always_comb begin
    s_d    = s_q;
    st_d   = st_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      s_d   = bus.seed_i;
      st_d  = bus.seed_i;
      cnt_d = '0;
    end else if (bus.en) begin
      s_d = ns;
      if (ns == st_q) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  assign bus.lockup_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q    <= SEED;
      st_q   <= SEED;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.lfsr_o  = s_q;
  assign bus.bit_o   = s_q[WIDTH-1];
  assign bus.count_o = cnt_q;
  assign bus.wrap_o  = wrap_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: directed test-plan cases, random stimulus vs. model, 8-bit period.
module tb_lfsr_gen;

`ifdef LFSR_LOCKUP_RECOVER_EN
  localparam bit RECOVER = 1'b1;
`else
  localparam bit RECOVER = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lfsr_gen_if #(.WIDTH(4)) b4 ();
  lfsr_gen_if #(.WIDTH(8)) b8 ();

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'hE)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(b4.slave)
  );
  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01)) dut8 (
    .clk(clk), .reset_n(reset_n), .bus(b8.slave)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  int m_s, m_st, m_cnt;
  bit m_wrap, m_lock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Next LFSR value: shift left, append parity of tapped bits, keep w bits.
  function automatic int lfsr_next(input int s, input int taps, input int w);
    return ((s << 1) | ($countones(s & taps) & 1)) & ((1 << w) - 1);
  endfunction

  task automatic model_reset();
    m_s = 14; m_st = 14; m_cnt = 0; m_wrap = 0; m_lock = 0;
  endtask

  task automatic model_clk(input bit en, input bit ld, input int seed);
    m_wrap = 0;
    m_lock = 0;
    if (ld) begin
      m_cnt = 0;
      if (RECOVER && seed == 0) begin
        m_s = 14; m_st = 14; m_lock = 1;
      end else begin
        m_s = seed; m_st = seed;
      end
    end else if (en) begin
      if (RECOVER && m_s == 0) begin
        m_s = 14; m_st = 14; m_cnt = 0; m_lock = 1;
      end else begin
        m_s = lfsr_next(m_s, 'hC, 4);
        if (m_s == m_st) begin
          m_cnt = 0; m_wrap = 1;
        end else begin
          m_cnt = (m_cnt + 1) % 16;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_lfsr"}, 32'(b4.lfsr_o), m_s);
    chk({tag, "_bit"}, 32'(b4.bit_o), (m_s >> 3) & 1);
    chk({tag, "_cnt"}, 32'(b4.count_o), m_cnt);
    chk({tag, "_wrap"}, 32'(b4.wrap_o), 32'(m_wrap));
    chk({tag, "_lock"}, 32'(b4.lockup_o), 32'(m_lock));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_clk(b4.en, b4.load, int'(b4.seed_i));
    #1;
    check_all(tag);
  endtask

  int tbl [15] = '{12, 8, 1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14};

  initial begin
    int w1, w2, nw, maxc, lfsr_at_wrap;
    b4.en = 0; b4.load = 0; b4.seed_i = '0;
    b8.en = 0; b8.load = 0; b8.seed_i = '0;

    #12;
    model_reset();
    check_all("reset");
    @(negedge clk) reset_n = 1;

    // Full default period from reset
    b4.en = 1;
    for (int i = 0; i < 15; i++) begin
      cyc("seq");
      chk("seq_tbl", 32'(b4.lfsr_o), tbl[i]);
      chk("seq_count", 32'(b4.count_o), (i < 14) ? i + 1 : 0);
      chk("seq_wrapflag", 32'(b4.wrap_o), (i == 14) ? 1 : 0);
    end

    // Advance to state 9, then idle
    for (int i = 0; i < 6; i++) cyc("to9");
    b4.en = 0;
    for (int i = 0; i < 5; i++) begin
      cyc("hold");
      chk("hold_lfsr", 32'(b4.lfsr_o), 9);
      chk("hold_count", 32'(b4.count_o), 6);
    end

    // load has priority over en
    b4.en = 1; b4.load = 1; b4.seed_i = 4'h3;
    cyc("ldpri");
    chk("ldpri_lfsr", 32'(b4.lfsr_o), 3);
    chk("ldpri_count", 32'(b4.count_o), 0);
    b4.load = 0;
    for (int i = 1; i <= 15; i++) begin
      cyc("ld3");
      chk("ld3_wrapflag", 32'(b4.wrap_o), (i == 15) ? 1 : 0);
      if (i == 1)  chk("ld3_first", 32'(b4.lfsr_o), 6);
      if (i == 15) chk("ld3_back", 32'(b4.lfsr_o), 3);
    end

    // Asynchronous reset between edges
    for (int i = 0; i < 4; i++) cyc("pre_arst");
    @(posedge clk);
    model_clk(b4.en, b4.load, int'(b4.seed_i));
    #3 reset_n = 0;
    #1;
    model_reset();
    check_all("arst");
    chk("arst_lfsr_e", 32'(b4.lfsr_o), 14);
    b4.en = 0;
    @(negedge clk) reset_n = 1;

    // Zero seed load
    b4.load = 1; b4.seed_i = '0;
    cyc("zload");
`ifdef LFSR_LOCKUP_RECOVER_EN
    chk("zload_lfsr", 32'(b4.lfsr_o), 14);
    chk("zload_lock", 32'(b4.lockup_o), 1);
`else
    chk("zload_lfsr", 32'(b4.lfsr_o), 0);
    chk("zload_lock", 32'(b4.lockup_o), 0);
`endif
    b4.load = 0; b4.en = 1;
    for (int i = 0; i < 3; i++) begin
      cyc("zstep");
`ifdef LFSR_LOCKUP_RECOVER_EN
      chk("zstep_lock", 32'(b4.lockup_o), 0);
`else
      chk("zstep_lfsr", 32'(b4.lfsr_o), 0);
      chk("zstep_wrap", 32'(b4.wrap_o), 1);
`endif
    end

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      b4.load   = ($urandom_range(0, 15) == 0);
      b4.en     = ($urandom_range(0, 3) != 0);
      b4.seed_i = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      cyc("rnd");
    end
    b4.load = 0; b4.en = 0;

    // 8-bit maximal-length period
    @(negedge clk) reset_n = 0;
    @(negedge clk) reset_n = 1;
    b8.en = 1;
    w1 = 0; w2 = 0; nw = 0; maxc = 0; lfsr_at_wrap = -1;
    for (int c = 1; c <= 700 && nw < 2; c++) begin
      @(posedge clk);
      #1;
      if (int'(b8.count_o) > maxc) maxc = int'(b8.count_o);
      if (b8.wrap_o) begin
        nw++;
        if (nw == 1) begin
          w1 = c;
          lfsr_at_wrap = int'(b8.lfsr_o);
        end else begin
          w2 = c;
        end
      end
    end
    chk("w8_wraps", nw, 2);
    chk("w8_first", w1, 255);
    chk("w8_period", w2 - w1, 255);
    chk("w8_peak", maxc, 254);
    chk("w8_wrapstate", lfsr_at_wrap, 1);
    b8.en = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR pseudo-random source, the next generation of the team's fixed 4-bit LFSR. It adds configurable width, tap mask and reset seed, a step enable, and a runtime seed load. It also tracks the sequence period: a step counter and a wrap pulse mark each return to the starting state. It sits beside test-pattern and scrambler logic as a free-running or gated random-number source.

## Interface
- WIDTH, 4: LFSR length in bits, 3..32.
- TAPS, 4'b1100: feedback tap mask, WIDTH bits. Bit i set means state bit i feeds the XOR.
- SEED, 4'hE: reset and recovery state, WIDTH bits. Must be nonzero.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  advance the LFSR by one step this cycle.
- load  in  1  load seed_i this cycle. Has priority over en.
- seed_i  in  WIDTH  runtime seed, sampled when load=1.
- lfsr_o  out  WIDTH  current state, registered.
- bit_o  out  1  serial output, equal to lfsr_o[WIDTH-1].
- count_o  out  WIDTH  enabled steps since the last start (reset, load or wrap).
- wrap_o  out  1  one-cycle pulse: the state has just returned to the start state.
- lockup_o  out  1  one-cycle pulse: an all-zero state was replaced by SEED.

## Operation
- State register s, start register st, counter cnt, all WIDTH bits.
- Feedback: fb = ^(s & TAPS). Next state: ns = {s[WIDTH-2:0], fb}.
- Reset (reset_n=0, asynchronous):
  - s=SEED, st=SEED, cnt=0.
  - wrap_o=0, lockup_o=0.
- Priority each cycle: load, then en, then hold.
- load=1:
  - s←seed_i, st←seed_i, cnt←0, wrap_o←0.
  - en is ignored that cycle.
- en=1, load=0:
  - s←ns.
  - If ns==st: cnt←0 and wrap_o←1. Otherwise cnt←cnt+1 and wrap_o←0.
- Idle (en=0, load=0): s, st and cnt hold; wrap_o←0, lockup_o←0.
- cnt is WIDTH bits. For a maximal tap set the period is 2^WIDTH−1, so cnt never exceeds 2^WIDTH−2. For a non-maximal tap set cnt wraps modulo 2^WIDTH with no error indication.
- Sequences that never return to st (transient entry states) never produce wrap_o. This is legal.
- No state machine beyond these registers. All outputs come directly from flops; bit_o is a wire taken from the s register.

## Timing
- Latency: lfsr_o shows the new state one cycle after the clk edge that sampled en or load.
- wrap_o rises in the same cycle that lfsr_o first equals st again, and stays high one cycle.
- lockup_o is registered and rises in the same cycle that lfsr_o shows SEED.
- Back-to-back en pulses advance one step per cycle. There is no handshake or backpressure.
- Reset asserted mid-sequence: outputs go to reset values immediately, without waiting for clk. Release is synchronous to the next clk edge; the design assumes release is synchronised upstream.
- load and en high together: only the load takes effect, with no step.

## Configuration
- LFSR_LOCKUP_RECOVER_EN defined:
  - A load with seed_i==0 stores SEED into both s and st instead, and pulses lockup_o.
  - An all-zero s during en, reachable only via a bad TAPS or an upset, is replaced by SEED. In that case cnt←0, st←SEED and lockup_o pulses.
- LFSR_LOCKUP_RECOVER_EN undefined:
  - A zero seed is stored as-is and the LFSR stays locked at 0.
  - Every enabled step then sees ns==st, so wrap_o pulses each step.
  - lockup_o is tied 0.

## Test plan
- Reset, then en=1 continuously with the defaults:
  - lfsr_o follows E,C,8,1,2,4,9,3,6,D,A,5,B,7,F,E.
  - wrap_o is high only at the return to E, 15 cycles later.
  - count_o runs 1..14, then 0 at the wrap.
- Hold en=0 for 5 cycles mid-sequence at state 9: lfsr_o stays 9, count_o holds, wrap_o stays 0.
- load=1 with seed_i=4'h3 and en=1 in the same cycle:
  - Next cycle lfsr_o=3 and count_o=0.
  - The sequence then continues 6,D,…, and wrap_o pulses on the next 3, 15 steps later.
- Assert reset_n=0 asynchronously between clk edges mid-sequence: lfsr_o=E, count_o=0 and all pulse outputs are 0 immediately, before the next clk edge.
- load seed_i=0, then en=1:
  - With the macro: lfsr_o=E and lockup_o=1 for one cycle.
  - Without the macro: lfsr_o stays 0, wrap_o=1 on every enabled step, and lockup_o=0.
- WIDTH=8, TAPS=8'hB8, SEED=8'h01, en continuous: exactly 255 steps between wrap_o pulses, and count_o peaks at 254.
